// File: rtl/mem_stage_pkg.sv
// Shared RV32I pipeline types for the memory stage: stage registers,
// load/store funct3 encodings and the memory FSM state enum.
package rv32i_types;

    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_f3_t;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic [4:0]  rd_s;
        logic [5:0]  dest_phys_new;
        logic [5:0]  dest_phys_old;
        logic [4:0]  dest_arch;
        logic        regf_we;
        logic [3:0]  regfilemux_sel;
        logic [31:0] alu_out;
        logic        br_en;
        logic [31:0] u_imm;
        logic [31:0] rs2_v;
    } ex_mem_stage_reg_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic [4:0]  rd_s;
        logic [5:0]  dest_phys_new;
        logic [5:0]  dest_phys_old;
        logic [4:0]  dest_arch;
        logic        regf_we;
        logic [3:0]  regfilemux_sel;
        logic [31:0] alu_out;
        logic        br_en;
        logic [31:0] u_imm;
        logic [31:0] load_data;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic        misaligned;
    } mem_wb_stage_reg_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane helper for the memory stage: access mask, store-data lane shift,
// load extract/extend and (with MEM_MISALIGN_CHECK_EN) misalignment detection.
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2_v,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [3:0]  base_mask;
    logic [31:0] rshift;

    // Size-based mask, shifted into the addressed lanes (truncated to 4 bits).
    always_comb begin
        base_mask = 4'b1111;
        case ({1'b0, funct3[1:0]})
            sb:      base_mask = 4'b0001;
            sh:      base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        mask  = base_mask << addr_lo;
        wdata = rs2_v << {addr_lo, 3'b000};
    end

    // Move the addressed bytes down to bit 0, then sign- or zero-extend.
    always_comb begin
        rshift    = rdata >> {addr_lo, 3'b000};
        load_data = rshift;
        case (funct3)
            lb:      load_data = {{24{rshift[7]}}, rshift[7:0]};
            lh:      load_data = {{16{rshift[15]}}, rshift[15:0]};
            lbu:     load_data = {24'b0, rshift[7:0]};
            lhu:     load_data = {16'b0, rshift[15:0]};
            default: load_data = rshift;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) ||
                        (funct3[1] && addr_lo != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues the data-memory request for loads/stores, stalls the
// upstream pipeline until dmem_resp, and registers the MEM/WB stage.
// Optional build macro: MEM_MISALIGN_CHECK_EN (suppress misaligned accesses).
module mem_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  ex_mem_stage_reg_t ex_mem,
    output mem_wb_stage_reg_t mem_wb,
    output logic              mem_stall,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp
);

    mem_state_t        state, state_next;
    mem_wb_stage_reg_t wb_next;
    logic              is_load, is_store, is_mem, mis, req;
    logic              align_mis;
    logic [3:0]        mask;
    logic [31:0]       load_data;

    mem_align u_align (
        .funct3    (ex_mem.inst[14:12]),
        .addr_lo   (ex_mem.alu_out[1:0]),
        .rs2_v     (ex_mem.rs2_v),
        .rdata     (dmem_rdata),
        .mask      (mask),
        .wdata     (dmem_wdata),
        .load_data (load_data),
        .misaligned(align_mis)
    );

    assign is_load   = ex_mem.valid && (ex_mem.inst[6:0] == op_load);
    assign is_store  = ex_mem.valid && (ex_mem.inst[6:0] == op_store);
    assign is_mem    = is_load || is_store;
    assign mis       = is_mem && align_mis;
    assign req       = is_mem && !mis;
    assign dmem_addr = {ex_mem.alu_out[31:2], 2'b00};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= MEM_IDLE;
        else     state <= state_next;
    end

    // Next state, request masks and stall.
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        if (!rst) begin
            case (state)
                MEM_IDLE: begin
                    if (req) begin
                        dmem_rmask = is_load  ? mask : 4'b0000;
                        dmem_wmask = is_store ? mask : 4'b0000;
                        mem_stall  = 1'b1;
                        state_next = MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_resp) state_next = MEM_IDLE;
                    else           mem_stall  = 1'b1;
                end
                default: state_next = MEM_IDLE;
            endcase
        end
    end

    // Assemble the MEM/WB contents; trace fields are zero for non-memory ops.
    always_comb begin
        wb_next                = '0;
        wb_next.pc             = ex_mem.pc;
        wb_next.inst           = ex_mem.inst;
        wb_next.valid          = ex_mem.valid;
        wb_next.rd_s           = ex_mem.rd_s;
        wb_next.dest_phys_new  = ex_mem.dest_phys_new;
        wb_next.dest_phys_old  = ex_mem.dest_phys_old;
        wb_next.dest_arch      = ex_mem.dest_arch;
        wb_next.regf_we        = ex_mem.regf_we && !mis;
        wb_next.regfilemux_sel = ex_mem.regfilemux_sel;
        wb_next.alu_out        = ex_mem.alu_out;
        wb_next.br_en          = ex_mem.br_en;
        wb_next.u_imm          = ex_mem.u_imm;
        wb_next.misaligned     = mis;
        if (is_mem) wb_next.mem_addr = dmem_addr;
        if (req && is_load) begin
            wb_next.load_data = load_data;
            wb_next.mem_rmask = mask;
            wb_next.mem_rdata = dmem_rdata;
        end
        if (req && is_store) begin
            wb_next.mem_wmask = mask;
            wb_next.mem_wdata = dmem_wdata;
        end
    end

    // MEM/WB register advances whenever the stage is not stalled.
    always_ff @(posedge clk) begin
        if (rst)             mem_wb <= '0;
        else if (!mem_stall) mem_wb <= wb_next;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    ex_mem_stage_reg_t ex_mem;
    mem_wb_stage_reg_t mem_wb;
    logic              mem_stall;
    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_rmask;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .ex_mem    (ex_mem),
        .mem_wb    (mem_wb),
        .mem_stall (mem_stall),
        .dmem_addr (dmem_addr),
        .dmem_rmask(dmem_rmask),
        .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_resp (dmem_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic we);
        ex_mem                = '0;
        ex_mem.valid          = 1'b1;
        ex_mem.pc             = 32'h0000_0100;
        ex_mem.inst           = {17'h0, f3, 5'd3, op};
        ex_mem.rd_s           = 5'd3;
        ex_mem.dest_phys_new  = 6'd33;
        ex_mem.dest_phys_old  = 6'd3;
        ex_mem.dest_arch      = 5'd3;
        ex_mem.regf_we        = we;
        ex_mem.regfilemux_sel = 4'd2;
        ex_mem.alu_out        = addr;
        ex_mem.rs2_v          = rs2;
        #1;
    endtask

    task automatic bubble();
        ex_mem = '0;
        #1;
    endtask

    initial begin
        rst = 1'b1; ex_mem = '0; dmem_rdata = '0; dmem_resp = 1'b0;
        tick(); tick();
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_masks", {24'b0, dmem_rmask, dmem_wmask}, 32'd0);
        chk("rst_valid", {31'b0, mem_wb.valid}, 32'd0);
        chk("rst_alu_out", mem_wb.alu_out, 32'd0);
        rst = 1'b0;

        // ALU op passes through in one edge with no stall.
        drive(7'b0110011, 3'b000, 32'h10, 32'h0, 1'b1);
        chk("alu_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        bubble();
        chk("alu_out", mem_wb.alu_out, 32'h10);
        chk("alu_valid", {31'b0, mem_wb.valid}, 32'd1);
        chk("alu_rename", {26'b0, mem_wb.dest_phys_new}, 32'd33);
        chk("alu_load_data", mem_wb.load_data, 32'd0);
        chk("alu_stall_after", {31'b0, mem_stall}, 32'd0);

        // LW at 0x1004, response after three wait cycles.
        drive(op_load, lw, 32'h1004, 32'h0, 1'b1);
        chk("lw_rmask", {28'b0, dmem_rmask}, 32'hF);
        chk("lw_addr", dmem_addr, 32'h1004);
        chk("lw_stall0", {31'b0, mem_stall}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("lw_wait_rmask", {28'b0, dmem_rmask}, 32'd0);
            chk("lw_wait_stall", {31'b0, mem_stall}, 32'd1);
        end
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
        chk("lw_resp_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        dmem_resp = 1'b0; bubble();
        chk("lw_load_data", mem_wb.load_data, 32'hDEADBEEF);
        chk("lw_trace_rmask", {28'b0, mem_wb.mem_rmask}, 32'hF);
        chk("lw_trace_addr", mem_wb.mem_addr, 32'h1004);
        chk("lw_valid", {31'b0, mem_wb.valid}, 32'd1);

        // LB at 0x1003 with the earliest response, then LBU back-to-back.
        drive(op_load, lb, 32'h1003, 32'h0, 1'b1);
        chk("lb_rmask", {28'b0, dmem_rmask}, 32'h8);
        chk("lb_addr", dmem_addr, 32'h1000);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'h80FFFFFF; #1;
        chk("lb_resp_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        dmem_resp = 1'b0;
        drive(op_load, lbu, 32'h1003, 32'h0, 1'b1);
        chk("lb_load_data", mem_wb.load_data, 32'hFFFFFF80);
        chk("lbu_rmask", {28'b0, dmem_rmask}, 32'h8);
        chk("lbu_stall0", {31'b0, mem_stall}, 32'd1);
        tick();
        dmem_resp = 1'b1; #1;
        tick();
        dmem_resp = 1'b0; bubble();
        chk("lbu_load_data", mem_wb.load_data, 32'h00000080);

        // SH at 0x2002.
        drive(op_store, sh, 32'h2002, 32'h1234ABCD, 1'b0);
        chk("sh_wmask", {28'b0, dmem_wmask}, 32'hC);
        chk("sh_rmask", {28'b0, dmem_rmask}, 32'h0);
        chk("sh_wdata", dmem_wdata, 32'hABCD0000);
        chk("sh_addr", dmem_addr, 32'h2000);
        tick();
        chk("sh_wait_wdata", dmem_wdata, 32'hABCD0000);
        dmem_resp = 1'b1; dmem_rdata = 32'h0; #1;
        tick();
        dmem_resp = 1'b0; bubble();
        chk("sh_trace_wmask", {28'b0, mem_wb.mem_wmask}, 32'hC);
        chk("sh_trace_wdata", mem_wb.mem_wdata, 32'hABCD0000);
        chk("sh_regf_we", {31'b0, mem_wb.regf_we}, 32'd0);
        chk("sh_load_data", mem_wb.load_data, 32'd0);

        // Reset while waiting, then a stray response.
        drive(op_load, lw, 32'h3000, 32'h0, 1'b1);
        tick();
        chk("rstw_stall", {31'b0, mem_stall}, 32'd1);
        rst = 1'b1; bubble();
        tick();
        rst = 1'b0; dmem_resp = 1'b1; #1;
        chk("rstw_stray_stall", {31'b0, mem_stall}, 32'd0);
        chk("rstw_stray_rmask", {28'b0, dmem_rmask}, 32'd0);
        tick();
        dmem_resp = 1'b0; #1;
        chk("rstw_valid", {31'b0, mem_wb.valid}, 32'd0);
        chk("rstw_idle_stall", {31'b0, mem_stall}, 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        drive(op_load, lw, 32'h1001, 32'h0, 1'b1);
        chk("mis_rmask", {28'b0, dmem_rmask}, 32'd0);
        chk("mis_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        bubble();
        chk("mis_flag", {31'b0, mem_wb.misaligned}, 32'd1);
        chk("mis_regf_we", {31'b0, mem_wb.regf_we}, 32'd0);
        chk("mis_valid", {31'b0, mem_wb.valid}, 32'd1);
`else
        drive(op_load, lw, 32'h1001, 32'h0, 1'b1);
        chk("unal_rmask", {28'b0, dmem_rmask}, 32'hE);
        chk("unal_addr", dmem_addr, 32'h1000);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'h11223344; #1;
        tick();
        dmem_resp = 1'b0; bubble();
        chk("unal_flag", {31'b0, mem_wb.misaligned}, 32'd0);
        chk("unal_load_data", mem_wb.load_data, 32'h00112233);
        chk("unal_regf_we", {31'b0, mem_wb.regf_we}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the in-order pipeline: consumes the EX/MEM stage register, performs the RV32I load/store data-memory transaction, and produces the registered MEM/WB stage register. It issues the data-memory request, holds the upstream pipeline with `mem_stall` until the response returns, aligns load data, and forwards all rename fields (`dest_phys_new`, `dest_phys_old`, `dest_arch`) unchanged to writeback.

## Interface
Parameters:
- none; widths are fixed at RV32I: 32-bit address and data, 4-bit byte masks.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ex_mem`  in  `ex_mem_stage_reg_t`  EX/MEM stage register contents.
- `mem_wb`  out  `mem_wb_stage_reg_t`  registered MEM/WB stage register.
- `mem_stall`  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers while high.
- `dmem_addr`  out  32  word-aligned address (`alu_out & ~3`).
- `dmem_rmask`  out  4  byte read mask; nonzero only in the request cycle.
- `dmem_wmask`  out  4  byte write mask; nonzero only in the request cycle.
- `dmem_wdata`  out  32  store data, lane-shifted.
- `dmem_rdata`  in  32  read data; valid when `dmem_resp` is high.
- `dmem_resp`  in  1  one-cycle response pulse for a read or a write.

## Operation
- Memory op: `ex_mem.valid` and opcode is LOAD or STORE. Every other valid instruction passes straight through.
- FSM has two states, IDLE and WAIT.
  - IDLE with a memory op: drive the request (masks nonzero), assert `mem_stall`, go to WAIT.
  - IDLE with no memory op: `mem_stall`=0.
  - WAIT: masks are 0 and `mem_stall`=1. On `dmem_resp`, `mem_stall`=0, `mem_wb` captures the result, and the FSM returns to IDLE.
- Load masks by `addr[1:0]`:
  - LB/LBU: `4'b0001 << a`.
  - LH/LHU: `4'b0011 << a`.
  - LW: `4'b1111`.
- Stores use the same masks. `wdata = rs2_v << (8*a)`.
- Load result: shift `dmem_rdata` right by `8*a`, then sign-extend (LB/LH) or zero-extend (LBU/LHU) to 32 bits.
- `mem_wb` loads on every rising edge where `mem_stall`=0.
  - Pass-through fields: pc, inst, valid, rd_s, rename fields, regf_we, regfilemux_sel, alu_out, br_en, u_imm.
  - Memory fields: load_data, plus mem_addr/rmask/wmask/wdata/rdata for commit tracing.
  - For non-memory ops, load_data and the trace fields are 0.
- Invalid `ex_mem` (bubble) propagates with `valid`=0 and never issues a request.

## Timing
- Reset: state IDLE, `mem_wb` all zero with `valid`=0, `mem_stall`=0, masks 0.
  - `rst` in WAIT abandons the transaction.
  - A `dmem_resp` arriving in IDLE with no request outstanding is ignored.
- Non-memory op: `mem_wb` valid on the next edge (latency 1).
- Memory op timing:
  - Cycle 0 issues the request.
  - The response arrives at the earliest in cycle 1; the cycle-1 response is captured in cycle 1.
  - `mem_wb` is updated at the edge ending the response cycle.
  - Minimum stall is 1 cycle (cycle 0 only).
- `dmem_addr` and `dmem_wdata` stay stable through WAIT, because `ex_mem` is frozen.
- Back-to-back memory ops: the second request issues in the cycle after the first response.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - Halfword access with `a[0]`=1 or word access with `a`≠0 issues no request and does not stall.
  - `mem_wb.misaligned`=1 and `regf_we`=0.
- Not defined:
  - The `misaligned` field is tied to 0.
  - Misaligned addresses access the aligned word with the shifted mask truncated to 4 bits.

## Structure
- Shared package `rv32i_types` holds:
  - `mem_wb_stage_reg_t`.
  - `load_f3_t` (lb, lh, lw, lbu, lhu) and `store_f3_t` (sb, sh, sw).
  - The mem FSM state enum.
- One combinational sub-module, `mem_align`: mask generation, store-data shift, and load extract/extend.

## Test plan
- ALU op (add, `alu_out`=0x10) → `mem_wb.alu_out`=0x10 one edge later; `mem_stall` never high.
- LW at 0x1004, `dmem_rdata`=0xDEADBEEF after 3 wait cycles → `rmask`=0xF for one cycle; stall for 4 cycles; `load_data`=0xDEADBEEF.
- LB at 0x1003, rdata=0x80FFFFFF → `rmask`=0x8; `load_data`=0xFFFFFF80. Same access as LBU → 0x00000080.
- SH at 0x2002 with `rs2_v`=0x1234ABCD → `wmask`=0xC; `wdata`=0xABCD0000; `regf_we` passes through unchanged.
- `rst` asserted while in WAIT, then a stray `dmem_resp` → FSM stays IDLE; `mem_wb.valid`=0; no stall.
- With `MEM_MISALIGN_CHECK_EN`: LW at 0x1001 → no mask asserted; `misaligned`=1; `regf_we`=0.
